// File: rtl/lanzones_mem_model.sv
// Parametrised simulation memory model for the lanzones bench: configurable latency, byte addressing, range error.
// Define MEM_RANDOM_STALL_EN to add 0..3 pseudo-random extra cycles of latency per request.
module lanzones_mem_model #(
    parameter int          DATA_W     = 32,
    parameter int          ADDR_W     = 32,
    parameter int          DEPTH_LOG2 = 16,
    parameter int          LATENCY    = 1,
    parameter int          BYTE_ADDR  = 0,
    parameter logic [7:0]  STALL_SEED = 8'hA5
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                RRdy,
    input  logic [ADDR_W-1:0]   RAddr,
    input  logic                RWEn,
    input  logic [DATA_W-1:0]   RWData,
    input  logic [DATA_W/8-1:0] RWStrobe,
    output logic                RVld,
    output logic [DATA_W-1:0]   RData,
    output logic                RErr
);

    // state | meaning
    // IDLE  | waiting for RRdy; request is captured on the accepting edge
    // WAIT  | latency countdown; request inputs ignored
    // RESP  | RVld high for one cycle with RData/RErr

    localparam int STRB_W     = DATA_W / 8;
    localparam int LANE_SHIFT = $clog2(STRB_W);
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [4:0]              cnt, cnt_nxt, cnt_load;
    logic [1:0]              stall;
    logic                    accept;
    logic                    enter_resp;
    logic [ADDR_W-1:0]       addr_q;
    logic                    wen_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [STRB_W-1:0]       strb_q;
    logic [ADDR_W-1:0]       idx;
    logic                    in_range;
    logic [DEPTH_LOG2-1:0]   mem_idx;
    logic [DATA_W-1:0]       rdata_q;
    logic                    rerr_q;
    logic [DATA_W-1:0]       mem [DEPTH];

    assign accept     = (state == IDLE) && RRdy;
    assign enter_resp = (state == WAIT) && (cnt == 5'd0);

`ifdef MEM_RANDOM_STALL_EN
    logic [7:0] lfsr;
    logic       lfsr_fb;

    // Fibonacci taps 8,6,5,4; the pre-advance value sets this request's stall
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr <= (STALL_SEED == 8'h00) ? 8'h01 : STALL_SEED;
        end else if (accept) begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end

    assign stall = lfsr[1:0];
`else
    assign stall = 2'd0;
`endif

    assign cnt_load = 5'(LATENCY - 1) + {3'd0, stall};

    assign idx      = (BYTE_ADDR != 0) ? (addr_q >> LANE_SHIFT) : addr_q;
    assign in_range = ((idx >> DEPTH_LOG2) == '0);
    assign mem_idx  = idx[DEPTH_LOG2-1:0];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (RRdy) begin
                    state_nxt = WAIT;
                    cnt_nxt   = cnt_load;
                end
            end
            WAIT: begin
                if (cnt == 5'd0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 5'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else if (accept) begin
            addr_q  <= RAddr;
            wen_q   <= RWEn;
            wdata_q <= RWData;
            strb_q  <= RWStrobe;
        end
    end

    // Response registers are zero outside the RESP cycle so RData/RErr are clean whenever RVld is low
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else if (enter_resp) begin
            rdata_q <= (in_range && !wen_q) ? mem[mem_idx] : '0;
            rerr_q  <= !in_range;
        end else begin
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (enter_resp && wen_q && in_range) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (strb_q[b]) begin
                    mem[mem_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign RVld  = (state == RESP);
    assign RData = rdata_q;
    assign RErr  = rerr_q;

endmodule

// File: tb/tb_lanzones_mem_model.sv
// Directed bench for lanzones_mem_model: three instances (LATENCY 1 word-addressed, LATENCY 4, LATENCY 3 byte-addressed).
module tb_lanzones_mem_model;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  rrdy = '0;
    logic [2:0]  rwen = '0;
    logic [31:0] raddr  [3];
    logic [31:0] rwdata [3];
    logic [3:0]  rwstrb [3];
    logic [2:0]  rvld;
    logic [2:0]  rerr;
    logic [31:0] rdata  [3];

    int n_pass = 0;
    int n_chk  = 0;

`ifdef MEM_RANDOM_STALL_EN
    localparam int STALL_MAX = 3;
`else
    localparam int STALL_MAX = 0;
`endif

    always #5 clk = ~clk;

    lanzones_mem_model #(.LATENCY(1)) mem (
        .clk(clk), .rstn(rstn), .RRdy(rrdy[0]), .RAddr(raddr[0]), .RWEn(rwen[0]),
        .RWData(rwdata[0]), .RWStrobe(rwstrb[0]), .RVld(rvld[0]), .RData(rdata[0]), .RErr(rerr[0])
    );

    lanzones_mem_model #(.LATENCY(4), .DEPTH_LOG2(8)) mem_l4 (
        .clk(clk), .rstn(rstn), .RRdy(rrdy[1]), .RAddr(raddr[1]), .RWEn(rwen[1]),
        .RWData(rwdata[1]), .RWStrobe(rwstrb[1]), .RVld(rvld[1]), .RData(rdata[1]), .RErr(rerr[1])
    );

    lanzones_mem_model #(.LATENCY(3), .DEPTH_LOG2(8), .BYTE_ADDR(1)) mem_b (
        .clk(clk), .rstn(rstn), .RRdy(rrdy[2]), .RAddr(raddr[2]), .RWEn(rwen[2]),
        .RWData(rwdata[2]), .RWStrobe(rwstrb[2]), .RVld(rvld[2]), .RData(rdata[2]), .RErr(rerr[2])
    );

    typedef struct {
        int          p;
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    // One request on port p; lat counts edges from acceptance to the first edge with RVld high
    task automatic txn(input int p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rd, output logic er,
                       output int lat, output logic after_ok);
        @(negedge clk);
        rrdy[p]   = 1'b1;
        rwen[p]   = we;
        raddr[p]  = a;
        rwdata[p] = wd;
        rwstrb[p] = st;
        @(posedge clk);
        #1;
        rrdy[p]   = 1'b0;
        rwen[p]   = 1'b0;
        raddr[p]  = 32'hFFFF_FFFF;
        rwdata[p] = 32'h0;
        rwstrb[p] = 4'h0;
        lat = 0;
        while (rvld[p] !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = rdata[p];
        er = rerr[p];
        @(posedge clk);
        #1;
        after_ok = (rvld[p] === 1'b0) && (rdata[p] === 32'h0) && (rerr[p] === 1'b0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        aok;
        int          lat;
        int          cyc;
        int          npulse;
        int          seen;
        int          pos  [3];
        logic [31:0] pdat [3];

        for (int i = 0; i < 3; i++) begin
            raddr[i]  = '0;
            rwdata[i] = '0;
            rwstrb[i] = '0;
        end

        vecs[0]  = '{0, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h1234_5678, 1'b0, 1};
        vecs[1]  = '{0, 1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0,         1'b0, 1};
        vecs[2]  = '{0, 1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_11DD, 1'b0, 1};
        vecs[3]  = '{0, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0, 1};
        vecs[4]  = '{0, 1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_11DD, 1'b0, 1};
        vecs[5]  = '{0, 1'b0, 32'h0001_0000, 32'h0,         4'h0, 32'h0,         1'b1, 1};
        vecs[6]  = '{0, 1'b1, 32'h0001_0000, 32'h0BAD_F00D, 4'hF, 32'h0,         1'b1, 1};
        vecs[7]  = '{0, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 1};
        vecs[8]  = '{0, 1'b1, 32'h0000_0020, 32'h2233_4455, 4'hA, 32'h0,         1'b0, 1};
        vecs[9]  = '{0, 1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h22BB_44DD, 1'b0, 1};
        vecs[10] = '{0, 1'b0, 32'h0000_FFFF, 32'h0,         4'h0, 32'h0F0F_0F0F, 1'b0, 1};
        vecs[11] = '{2, 1'b1, 32'h0000_0008, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0, 3};
        vecs[12] = '{2, 1'b0, 32'h0000_0008, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0, 3};
        vecs[13] = '{2, 1'b0, 32'h0000_0009, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0, 3};
        vecs[14] = '{2, 1'b0, 32'h0000_0400, 32'h0,         4'h0, 32'h0,         1'b1, 3};
        vecs[15] = '{2, 1'b0, 32'h0000_03FC, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0, 3};
        vecs[16] = '{2, 1'b1, 32'h0000_0400, 32'h7777_7777, 4'hF, 32'h0,         1'b1, 3};
        vecs[17] = '{2, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0000_0B0B, 1'b0, 3};

        mem.mem[16'h0010]  = 32'h1234_5678;
        mem.mem[16'h0020]  = 32'h1111_1111;
        mem.mem[16'h0000]  = 32'hDEAD_BEEF;
        mem.mem[16'hFFFF]  = 32'h0F0F_0F0F;
        mem_l4.mem[1]      = 32'hA1A1_A1A1;
        mem_l4.mem[2]      = 32'hB2B2_B2B2;
        mem_l4.mem[3]      = 32'hC3C3_C3C3;
        mem_b.mem[0]       = 32'h0000_0B0B;
        mem_b.mem[2]       = 32'h0000_0000;
        mem_b.mem[5]       = 32'h5555_5555;
        mem_b.mem[255]     = 32'hA5A5_A5A5;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rvld", {29'b0, rvld}, 32'h0);
        chk("rst_rerr", {29'b0, rerr}, 32'h0);
        chk("rst_rdata0", rdata[0], 32'h0);
        chk("rst_rdata2", rdata[2], 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        for (int v = 0; v < NVEC; v++) begin
            txn(vecs[v].p, vecs[v].we, vecs[v].a, vecs[v].wd, vecs[v].st, rd, er, lat, aok);
            chk($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rd);
            chk($sformatf("vec%0d_rerr", v), {31'b0, er}, {31'b0, vecs[v].exp_err});
            chk_range($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat, vecs[v].exp_lat + STALL_MAX);
            chk($sformatf("vec%0d_after", v), {31'b0, aok}, 32'h1);
        end

        // Back-to-back reads with RRdy held high on the LATENCY=4 instance
        @(negedge clk);
        raddr[1] = 32'h1;
        rwen[1]  = 1'b0;
        rrdy[1]  = 1'b1;
        @(posedge clk);
        #1;
        cyc    = 0;
        npulse = 0;
        while (cyc < 60 && npulse < 3) begin
            @(posedge clk);
            #1;
            cyc++;
            if (rvld[1]) begin
                pos[npulse]  = cyc;
                pdat[npulse] = rdata[1];
                npulse++;
                raddr[1] = 32'(npulse + 1);
                if (npulse == 3) rrdy[1] = 1'b0;
            end
        end
        chk_range("b2b_pulses", npulse, 3, 3);
        if (npulse == 3) begin
            chk_range("b2b_first_lat", pos[0], 4, 4 + STALL_MAX);
            chk_range("b2b_gap1", pos[1] - pos[0], 6, 6 + STALL_MAX);
            chk_range("b2b_gap2", pos[2] - pos[1], 6, 6 + STALL_MAX);
            chk("b2b_data0", pdat[0], 32'hA1A1_A1A1);
            chk("b2b_data1", pdat[1], 32'hB2B2_B2B2);
            chk("b2b_data2", pdat[2], 32'hC3C3_C3C3);
        end
        rrdy[1] = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (rvld[1]) seen++;
        end
        chk_range("b2b_no_extra", seen, 0, 0);

        // Reset one cycle after accepting a write on the LATENCY=3 instance
        @(negedge clk);
        rrdy[2]   = 1'b1;
        rwen[2]   = 1'b1;
        raddr[2]  = 32'h0000_0014;
        rwdata[2] = 32'h9999_9999;
        rwstrb[2] = 4'hF;
        @(posedge clk);
        #1;
        rrdy[2]   = 1'b0;
        rwen[2]   = 1'b0;
        rwstrb[2] = 4'h0;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (rvld[2]) seen++;
        end
        rstn = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (rvld[2]) seen++;
        end
        chk_range("rst_wait_no_rvld", seen, 0, 0);
        txn(2, 1'b0, 32'h0000_0014, 32'h0, 4'h0, rd, er, lat, aok);
        chk("rst_wait_old_data", rd, 32'h5555_5555);

        // Reset during RESP clears outputs asynchronously
        @(negedge clk);
        rrdy[0]  = 1'b1;
        rwen[0]  = 1'b0;
        raddr[0] = 32'h0000_0010;
        @(posedge clk);
        #1;
        rrdy[0] = 1'b0;
        cyc = 0;
        while (rvld[0] !== 1'b1 && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rst_resp_pre_data", rdata[0], 32'h1234_5678);
        rstn = 1'b0;
        #1;
        chk("rst_resp_rvld", {31'b0, rvld[0]}, 32'h0);
        chk("rst_resp_rdata", rdata[0], 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Twenty reads on the LATENCY=3 instance; latency may stretch by up to 3 only with stalls enabled
        for (int k = 0; k < 20; k++) begin
            txn(2, 1'b0, 32'h0000_0008, 32'h0, 4'h0, rd, er, lat, aok);
            chk_range($sformatf("stall_lat%0d", k), lat, 3, 3 + STALL_MAX);
            chk($sformatf("stall_data%0d", k), rd, 32'hCAFE_F00D);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
